axis_kvs_latency_monitor: RTL and testbench
===========================================

// Module: axis_kvs_latency_monitor
// PURPOSE
//  In-fabric request/response monitor for the KVS-over-PCIe path. Sits between the PCIe AXI-Stream endpoint and the KVS pipeline.
//  Passes request and response packets through. Caps the number of outstanding requests, supports a fence (drain) and timestamps each request.
//  Pairs each request with its response in FIFO order and accumulates count, min, max and sum latency for host readout.
// PARAMETERS
//  DATA_WIDTH       256  AXIS tdata width (multiple of 8)
//  USER_WIDTH       64   AXIS tuser width, passed through untouched
//  MAX_OUTSTANDING  16   timestamp FIFO depth = outstanding cap; power of 2, >=2
//  TS_WIDTH         48   free-running timestamp width, in clk cycles
//  CNT_WIDTH        64   width of packet counters and the latency sum
// PORTS
//  clk             in   1                 single clock for all logic
//  sys_rst         in   1                 asynchronous, active-high reset
//  s_req_t{data,keep,user,valid,last} / s_req_tready     in/out   DW,DW/8,UW,1,1 / 1   requests from host
//  m_req_t{data,keep,user,valid,last} / m_req_tready     out/in   same                 requests to KVS
//  s_rsp_t{data,keep,user,valid,last} / s_rsp_tready     in/out   same                 responses from KVS
//  m_rsp_t{data,keep,user,valid,last} / m_rsp_tready     out/in   same                 responses to host
//  enable          in   1          admit new request packets while high
//  fence           in   1          1-cycle pulse: stop admitting new requests until outstanding==0
//  clear_stats     in   1          1-cycle pulse: zero all statistics
//  fence_busy      out  1          high while a fence is draining
//  outstanding     out  $clog2(MO)+1   requests sent minus responses matched
//  nr_req_sent     out  CNT_WIDTH  request packets whose head beat was accepted
//  nr_rsp_recv     out  CNT_WIDTH  response packets whose tlast beat was accepted
//  lat_min/lat_max out  TS_WIDTH   min/max matched latency in cycles
//  lat_sum         out  CNT_WIDTH  sum of matched latencies; wraps modulo 2^CNT_WIDTH
//  err_unmatched   out  1          sticky: response tlast arrived with the FIFO empty
// BEHAVIOUR
//  Reset: state IDLE, in_pkt=0, FIFO empty, ts=0.
//   Counters, lat_sum, lat_max and outstanding reset to 0; lat_min to all-ones; fence_busy=0; err_unmatched=0.
//   m_req_tvalid and s_req_tready are 0 during reset.
//  FSM states:
//   IDLE: enable=0. Goes to OPEN when enable=1.
//   OPEN: heads are admitted. Goes to FENCE on a fence pulse. Goes to IDLE when enable=0.
//   FENCE: fence_busy=1. Goes to OPEN, or to IDLE if enable=0, in the cycle after outstanding==0 is seen.
//   A fence pulse while in FENCE is ignored. A fence pulse in IDLE goes to FENCE.
//  Request gate: pass = in_pkt | (state==OPEN & outstanding<MAX_OUTSTANDING).
//   m_req_tvalid = s_req_tvalid & pass; s_req_tready = m_req_tready & pass. Data, keep, user and last are wired through combinationally.
//   A packet, once its head is accepted, always runs to tlast, regardless of enable, fence or cap.
//  Head beat = accepted beat with in_pkt=0. On a head beat: push ts into the FIFO, nr_req_sent++, outstanding++.
//   in_pkt is set on a non-last head beat and cleared on an accepted tlast beat.
//  Response path is a pure combinational pass-through: s_rsp_tready = m_rsp_tready; no gating.
//  On an accepted response tlast beat:
//   nr_rsp_recv++.
//   If the FIFO is non-empty: pop, lat = ts - popped (mod 2^TS_WIDTH; wrap-safe). Update min/max and add lat to lat_sum. outstanding--.
//   If the FIFO is empty: set err_unmatched; no pop; latency stats unchanged.
//  Same-cycle push and pop: both occur; outstanding is unchanged.
//   A pop uses only entries pushed in earlier cycles. A same-cycle push into an empty FIFO counts as unmatched.
//  clear_stats has priority over a same-cycle stat update for counters, min/max/sum and err_unmatched.
//   It does not touch the FIFO, outstanding, the FSM or in_pkt.
//  ts: free-running TS_WIDTH counter, +1 every cycle, wraps.
//  Latency of a beat = cycles from head-beat acceptance to response-tlast acceptance. Minimum is 1 in the same-cycle-excluded case.
//  All stat outputs are registered and update the cycle after the triggering event.
// STRUCTURE
//  Package kvs_mon_pkg holds the mon_state_t enum (IDLE, OPEN, FENCE) and the localparams for OUT_W and the lat_min reset value.
//  Sub-module mon_ts_fifo holds the timestamps: sync FIFO, depth MAX_OUTSTANDING, width TS_WIDTH, registered full/empty/count.
//   outstanding is driven from its count.
//  Top level contains the FSM, the gating logic, in_pkt and the statistics registers.
// TESTING
//  1. 4 single-beat requests; KVS echoes each after 10 cycles.
//     -> nr_req_sent=4, nr_rsp_recv=4, lat_min=lat_max=10, lat_sum=40, outstanding=0.
//  2. MAX_OUTSTANDING=16; 20 queued requests, m_rsp stalled.
//     -> exactly 16 heads forwarded and s_req_tready low.
//     -> Release 1 response -> the 17th head is admitted the next cycle.
//  3. 3-beat request mid-packet when a fence pulse and enable=0 arrive.
//     -> the packet completes through tlast and no new head passes.
//     -> fence_busy falls the cycle after the last response.
//  4. Response tlast with no request sent -> err_unmatched=1, nr_rsp_recv=1, lat stats unchanged.
//     -> clear_stats -> all zero, lat_min=all-ones.
//  5. TS_WIDTH=8: head accepted at ts=250, response at ts=4 (wrapped) -> lat=10.
//  6. Assert sys_rst mid-packet with 3 outstanding.
//     -> all outputs return to reset values asynchronously and traffic resumes cleanly after release.

Source files
------------

// File: rtl/kvs_mon_pkg.sv
// Shared types and constants for the KVS request/response latency monitor.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package kvs_mon_pkg;

   // Admission state of the request gate.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OPEN  = 2'd1,
      FENCE = 2'd2
   } mon_state_t;

   // Widest timestamp supported; lat_min resets to the low TS_WIDTH bits of this.
   localparam int TS_WIDTH_MAX = 64;
   localparam logic [TS_WIDTH_MAX-1:0] LAT_MIN_RST = '1;

   // Width of the outstanding count: it must hold the value max_out itself.
   function automatic int out_w(input int max_out);
      return $clog2(max_out) + 1;
   endfunction

endpackage

// File: rtl/mon_ts_fifo.sv
// Timestamp FIFO: one entry per request in flight, popped in order as responses complete.
// Latency: pop_data shows the oldest entry combinationally; a push becomes visible the cycle after.
// Backpressure: none internally; push while full and pop while empty are ignored.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     write one timestamp
//   pop, pop_data       read/discard the oldest timestamp
//   full, empty, count  registered occupancy flags and count (0..DEPTH)
module mon_ts_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 48
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [CW-1:0]    count_nxt;

   // Pop looks only at the registered empty flag, so an entry written this
   // cycle can never be consumed in the same cycle.
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (do_push & ~do_pop) begin
         count_nxt = count + 1'b1;
      end else if (do_pop & ~do_push) begin
         count_nxt = count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/axis_kvs_latency_monitor.sv
// KVS request/response monitor: gates request heads (enable, outstanding cap, fence),
// timestamps each head and pairs it in order with the response tlast to collect latency stats.
// Latency: data paths are combinational pass-through; stats/outstanding update the cycle after the event.
// Backpressure: request ready follows m_req_tready when the gate is open, else 0; response path is ungated.
//
// Ports:
//   clk, sys_rst                      clock, asynchronous active-high reset
//   s_req_* / m_req_*                 AXIS requests host -> KVS (gated on heads only)
//   s_rsp_* / m_rsp_*                 AXIS responses KVS -> host (pure pass-through)
//   enable, fence, clear_stats        control: admit heads, drain pulse, zero stats pulse
//   fence_busy, outstanding           drain status and requests in flight
//   nr_req_sent, nr_rsp_recv          packet counters
//   lat_min, lat_max, lat_sum         latency statistics in clk cycles
//   err_unmatched                     sticky: response completed with nothing in flight
module axis_kvs_latency_monitor
   import kvs_mon_pkg::*;
#(
   parameter int DATA_WIDTH      = 256,
   parameter int USER_WIDTH      = 64,
   parameter int MAX_OUTSTANDING = 16,
   parameter int TS_WIDTH        = 48,
   parameter int CNT_WIDTH       = 64
) (
   input  logic                             clk,
   input  logic                             sys_rst,

   input  logic [DATA_WIDTH-1:0]            s_req_tdata,
   input  logic [DATA_WIDTH/8-1:0]          s_req_tkeep,
   input  logic [USER_WIDTH-1:0]            s_req_tuser,
   input  logic                             s_req_tvalid,
   input  logic                             s_req_tlast,
   output logic                             s_req_tready,

   output logic [DATA_WIDTH-1:0]            m_req_tdata,
   output logic [DATA_WIDTH/8-1:0]          m_req_tkeep,
   output logic [USER_WIDTH-1:0]            m_req_tuser,
   output logic                             m_req_tvalid,
   output logic                             m_req_tlast,
   input  logic                             m_req_tready,

   input  logic [DATA_WIDTH-1:0]            s_rsp_tdata,
   input  logic [DATA_WIDTH/8-1:0]          s_rsp_tkeep,
   input  logic [USER_WIDTH-1:0]            s_rsp_tuser,
   input  logic                             s_rsp_tvalid,
   input  logic                             s_rsp_tlast,
   output logic                             s_rsp_tready,

   output logic [DATA_WIDTH-1:0]            m_rsp_tdata,
   output logic [DATA_WIDTH/8-1:0]          m_rsp_tkeep,
   output logic [USER_WIDTH-1:0]            m_rsp_tuser,
   output logic                             m_rsp_tvalid,
   output logic                             m_rsp_tlast,
   input  logic                             m_rsp_tready,

   input  logic                             enable,
   input  logic                             fence,
   input  logic                             clear_stats,
   output logic                             fence_busy,
   output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
   output logic [CNT_WIDTH-1:0]             nr_req_sent,
   output logic [CNT_WIDTH-1:0]             nr_rsp_recv,
   output logic [TS_WIDTH-1:0]              lat_min,
   output logic [TS_WIDTH-1:0]              lat_max,
   output logic [CNT_WIDTH-1:0]             lat_sum,
   output logic                             err_unmatched
);

   localparam int OUT_W = out_w(MAX_OUTSTANDING);
   localparam logic [TS_WIDTH-1:0] LAT_MIN_INIT = LAT_MIN_RST[TS_WIDTH-1:0];

   mon_state_t          state;
   logic                in_pkt;
   logic [TS_WIDTH-1:0] ts;

   logic                pass;
   logic                req_acc;
   logic                head_acc;
   logic                rsp_last_acc;
   logic                matched;
   logic [TS_WIDTH-1:0] head_ts;
   logic [TS_WIDTH-1:0] lat;
   logic                fifo_full;
   logic                fifo_empty;
   logic [OUT_W-1:0]    fifo_count;

   // ------------------------------------------------------------------
   // Request gate. A packet already in progress always finishes; only
   // heads are subject to the FSM and the cap. The FIFO full flag is the
   // registered "outstanding == MAX_OUTSTANDING", so a slot freed by a
   // response opens the gate one cycle later.
   // ------------------------------------------------------------------
   assign pass         = in_pkt | ((state == OPEN) & ~fifo_full);
   assign m_req_tvalid = s_req_tvalid & pass;
   assign s_req_tready = m_req_tready & pass;
   assign m_req_tdata  = s_req_tdata;
   assign m_req_tkeep  = s_req_tkeep;
   assign m_req_tuser  = s_req_tuser;
   assign m_req_tlast  = s_req_tlast;

   assign req_acc  = s_req_tvalid & m_req_tready & pass;
   assign head_acc = req_acc & ~in_pkt;

   // Response path is never gated.
   assign m_rsp_tvalid = s_rsp_tvalid;
   assign s_rsp_tready = m_rsp_tready;
   assign m_rsp_tdata  = s_rsp_tdata;
   assign m_rsp_tkeep  = s_rsp_tkeep;
   assign m_rsp_tuser  = s_rsp_tuser;
   assign m_rsp_tlast  = s_rsp_tlast;

   assign rsp_last_acc = s_rsp_tvalid & m_rsp_tready & s_rsp_tlast;

   // Registered empty: a head pushed this same cycle does not satisfy the pop.
   assign matched = rsp_last_acc & ~fifo_empty;
   // Modular subtraction keeps the result right across timestamp wrap.
   assign lat     = ts - head_ts;

   mon_ts_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (TS_WIDTH)
   ) u_ts_fifo (
      .clk       (clk),
      .rst       (sys_rst),
      .push      (head_acc),
      .push_data (ts),
      .pop       (rsp_last_acc),
      .pop_data  (head_ts),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign outstanding = fifo_count;

   // ------------------------------------------------------------------
   // Admission FSM. fence wins over enable so a drain request is never lost.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         fence_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (fence) begin
                  state      <= FENCE;
                  fence_busy <= 1'b1;
               end else if (enable) begin
                  state <= OPEN;
               end
            end
            OPEN: begin
               if (fence) begin
                  state      <= FENCE;
                  fence_busy <= 1'b1;
               end else if (!enable) begin
                  state <= IDLE;
               end
            end
            FENCE: begin
               if (outstanding == '0) begin
                  state      <= enable ? OPEN : IDLE;
                  fence_busy <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               fence_busy <= 1'b0;
            end
         endcase
      end
   end

   // Free-running timestamp and packet framing.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         ts     <= '0;
         in_pkt <= 1'b0;
      end else begin
         ts <= ts + 1'b1;
         if (req_acc) begin
            in_pkt <= ~s_req_tlast;
         end
      end
   end

   // ------------------------------------------------------------------
   // Statistics. clear_stats overrides any update in the same cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         nr_req_sent   <= '0;
         nr_rsp_recv   <= '0;
         lat_min       <= LAT_MIN_INIT;
         lat_max       <= '0;
         lat_sum       <= '0;
         err_unmatched <= 1'b0;
      end else if (clear_stats) begin
         nr_req_sent   <= '0;
         nr_rsp_recv   <= '0;
         lat_min       <= LAT_MIN_INIT;
         lat_max       <= '0;
         lat_sum       <= '0;
         err_unmatched <= 1'b0;
      end else begin
         if (head_acc) begin
            nr_req_sent <= nr_req_sent + 1'b1;
         end
         if (rsp_last_acc) begin
            nr_rsp_recv <= nr_rsp_recv + 1'b1;
         end
         if (rsp_last_acc & fifo_empty) begin
            err_unmatched <= 1'b1;
         end
         if (matched) begin
            if (lat < lat_min) begin
               lat_min <= lat;
            end
            if (lat > lat_max) begin
               lat_max <= lat;
            end
            lat_sum <= lat_sum + CNT_WIDTH'(lat);
         end
      end
   end

endmodule

// File: tb/tb_axis_kvs_latency_monitor.sv
// Bench for axis_kvs_latency_monitor: directed traffic, a queue-based reference
// model checked every cycle, plus literal expectations at key points.
module tb_axis_kvs_latency_monitor;

   localparam int DW  = 32;
   localparam int UW  = 8;
   localparam int MO  = 16;
   localparam int TSW = 8;
   localparam int CW  = 32;

   logic clk = 1'b0;
   logic sys_rst;

   logic [DW-1:0]   s_req_tdata, m_req_tdata, s_rsp_tdata, m_rsp_tdata;
   logic [DW/8-1:0] s_req_tkeep, m_req_tkeep, s_rsp_tkeep, m_rsp_tkeep;
   logic [UW-1:0]   s_req_tuser, m_req_tuser, s_rsp_tuser, m_rsp_tuser;
   logic s_req_tvalid, s_req_tlast, s_req_tready;
   logic m_req_tvalid, m_req_tlast, m_req_tready;
   logic s_rsp_tvalid, s_rsp_tlast, s_rsp_tready;
   logic m_rsp_tvalid, m_rsp_tlast, m_rsp_tready;
   logic enable, fence, clear_stats, fence_busy, err_unmatched;
   logic [4:0]      outstanding;
   logic [CW-1:0]   nr_req_sent, nr_rsp_recv, lat_sum;
   logic [TSW-1:0]  lat_min, lat_max;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axis_kvs_latency_monitor #(
      .DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_OUTSTANDING(MO),
      .TS_WIDTH(TSW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .sys_rst(sys_rst),
      .s_req_tdata(s_req_tdata), .s_req_tkeep(s_req_tkeep), .s_req_tuser(s_req_tuser),
      .s_req_tvalid(s_req_tvalid), .s_req_tlast(s_req_tlast), .s_req_tready(s_req_tready),
      .m_req_tdata(m_req_tdata), .m_req_tkeep(m_req_tkeep), .m_req_tuser(m_req_tuser),
      .m_req_tvalid(m_req_tvalid), .m_req_tlast(m_req_tlast), .m_req_tready(m_req_tready),
      .s_rsp_tdata(s_rsp_tdata), .s_rsp_tkeep(s_rsp_tkeep), .s_rsp_tuser(s_rsp_tuser),
      .s_rsp_tvalid(s_rsp_tvalid), .s_rsp_tlast(s_rsp_tlast), .s_rsp_tready(s_rsp_tready),
      .m_rsp_tdata(m_rsp_tdata), .m_rsp_tkeep(m_rsp_tkeep), .m_rsp_tuser(m_rsp_tuser),
      .m_rsp_tvalid(m_rsp_tvalid), .m_rsp_tlast(m_rsp_tlast), .m_rsp_tready(m_rsp_tready),
      .enable(enable), .fence(fence), .clear_stats(clear_stats),
      .fence_busy(fence_busy), .outstanding(outstanding),
      .nr_req_sent(nr_req_sent), .nr_rsp_recv(nr_rsp_recv),
      .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum),
      .err_unmatched(err_unmatched)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   localparam int MS_IDLE = 0, MS_OPEN = 1, MS_FENCE = 2;
   int             ms;
   bit             m_in_pkt;
   logic [TSW-1:0] m_ts;
   logic [TSW-1:0] tsq[$];
   logic [CW-1:0]  e_req, e_rsp, e_sum;
   logic [TSW-1:0] e_min, e_max;
   bit             e_err;
   bit             m_req_acc, m_rsp_last;
   int             m_nxt;
   logic [TSW-1:0] m_lat;

   function automatic bit m_pass();
      return m_in_pkt || (ms == MS_OPEN && tsq.size() < MO);
   endfunction

   always @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         ms = MS_IDLE; m_in_pkt = 0; m_ts = '0; tsq.delete();
         e_req = '0; e_rsp = '0; e_sum = '0; e_min = '1; e_max = '0; e_err = 0;
      end else begin
         m_req_acc  = s_req_tvalid && m_req_tready && m_pass();
         m_rsp_last = s_rsp_tvalid && m_rsp_tready && s_rsp_tlast;
         m_nxt = ms;
         case (ms)
            MS_IDLE:  if (fence) m_nxt = MS_FENCE; else if (enable) m_nxt = MS_OPEN;
            MS_OPEN:  if (fence) m_nxt = MS_FENCE; else if (!enable) m_nxt = MS_IDLE;
            default:  if (tsq.size() == 0) m_nxt = enable ? MS_OPEN : MS_IDLE;
         endcase
         // completions consume only heads from earlier cycles
         if (m_rsp_last) begin
            e_rsp = e_rsp + 1;
            if (tsq.size() > 0) begin
               m_lat = m_ts - tsq.pop_front();
               if (m_lat < e_min) e_min = m_lat;
               if (m_lat > e_max) e_max = m_lat;
               e_sum = e_sum + CW'(m_lat);
            end else begin
               e_err = 1;
            end
         end
         if (m_req_acc && !m_in_pkt) begin
            tsq.push_back(m_ts);
            e_req = e_req + 1;
         end
         if (m_req_acc) m_in_pkt = !s_req_tlast;
         if (clear_stats) begin
            e_req = '0; e_rsp = '0; e_sum = '0; e_min = '1; e_max = '0; e_err = 0;
         end
         ms   = m_nxt;
         m_ts = m_ts + 1'b1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("m_req_tvalid", m_req_tvalid, s_req_tvalid && m_pass());
      chk("s_req_tready", s_req_tready, m_req_tready && m_pass());
      chk("m_req_tdata",  m_req_tdata,  s_req_tdata);
      chk("m_req_tkeep",  m_req_tkeep,  s_req_tkeep);
      chk("m_req_tuser",  m_req_tuser,  s_req_tuser);
      chk("m_req_tlast",  m_req_tlast,  s_req_tlast);
      chk("m_rsp_tvalid", m_rsp_tvalid, s_rsp_tvalid);
      chk("s_rsp_tready", s_rsp_tready, m_rsp_tready);
      chk("m_rsp_tdata",  m_rsp_tdata,  s_rsp_tdata);
      chk("m_rsp_tlast",  m_rsp_tlast,  s_rsp_tlast);
      chk("outstanding",  outstanding,  tsq.size());
      chk("fence_busy",   fence_busy,   ms == MS_FENCE);
      chk("nr_req_sent",  nr_req_sent,  e_req);
      chk("nr_rsp_recv",  nr_rsp_recv,  e_rsp);
      chk("lat_min",      lat_min,      e_min);
      chk("lat_max",      lat_max,      e_max);
      chk("lat_sum",      lat_sum,      e_sum);
      chk("err_unmatched", err_unmatched, e_err);
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_req(input bit last);
      s_req_tvalid = 1'b1;
      s_req_tlast  = last;
      s_req_tdata  = $urandom;
      s_req_tkeep  = DW/8'($urandom);
      s_req_tuser  = UW'($urandom);
   endtask

   task automatic drive_rsp(input bit last);
      s_rsp_tvalid = 1'b1;
      s_rsp_tlast  = last;
      s_rsp_tdata  = $urandom;
      s_rsp_tkeep  = DW/8'($urandom);
      s_rsp_tuser  = UW'($urandom);
   endtask

   task automatic pulse_clear();
      clear_stats = 1'b1;
      step(1);
      clear_stats = 1'b0;
   endtask

   initial begin
      sys_rst = 1'b1;
      s_req_tvalid = 1'b1; s_req_tlast = 1'b1; s_req_tdata = '0; s_req_tkeep = '0; s_req_tuser = '0;
      s_rsp_tvalid = 1'b0; s_rsp_tlast = 1'b0; s_rsp_tdata = '0; s_rsp_tkeep = '0; s_rsp_tuser = '0;
      m_req_tready = 1'b1; m_rsp_tready = 1'b1;
      enable = 1'b1; fence = 1'b0; clear_stats = 1'b0;
      step(3);

      // reset state, with a request offered and enable high
      chk("rst_s_req_tready", s_req_tready, 1'b0);
      chk("rst_m_req_tvalid", m_req_tvalid, 1'b0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_lat_min", lat_min, 8'hff);
      chk("rst_nr_req_sent", nr_req_sent, 0);
      chk("rst_fence_busy", fence_busy, 1'b0);
      s_req_tvalid = 1'b0;
      sys_rst = 1'b0;
      step(1);

      // 1: four single-beat requests, each echoed 10 cycles later
      for (int i = 0; i < 4; i++) begin
         drive_req(1'b1);
         step(1);
      end
      s_req_tvalid = 1'b0;
      step(6);
      for (int i = 0; i < 4; i++) begin
         drive_rsp(1'b1);
         step(1);
      end
      s_rsp_tvalid = 1'b0;
      chk("t1_nr_req_sent", nr_req_sent, 4);
      chk("t1_nr_rsp_recv", nr_rsp_recv, 4);
      chk("t1_lat_min", lat_min, 10);
      chk("t1_lat_max", lat_max, 10);
      chk("t1_lat_sum", lat_sum, 40);
      chk("t1_outstanding", outstanding, 0);

      // 2: outstanding cap with host response side stalled
      pulse_clear();
      m_rsp_tready = 1'b0;
      drive_rsp(1'b1);
      for (int i = 0; i < 20; i++) begin
         drive_req(1'b1);
         step(1);
      end
      chk("t2_nr_req_sent_cap", nr_req_sent, 16);
      chk("t2_outstanding_cap", outstanding, 16);
      chk("t2_s_req_tready_cap", s_req_tready, 1'b0);
      m_rsp_tready = 1'b1;
      step(1);
      m_rsp_tready = 1'b0;
      chk("t2_ready_after_release", s_req_tready, 1'b1);
      chk("t2_outstanding_release", outstanding, 15);
      step(1);
      chk("t2_nr_req_sent_17", nr_req_sent, 17);
      chk("t2_outstanding_refill", outstanding, 16);
      s_req_tvalid = 1'b0;
      m_rsp_tready = 1'b1;
      step(16);
      s_rsp_tvalid = 1'b0;
      chk("t2_outstanding_drained", outstanding, 0);
      chk("t2_nr_rsp_recv", nr_rsp_recv, 17);

      // 3: fence and enable drop in the middle of a 3-beat request
      pulse_clear();
      drive_req(1'b0);
      step(1);
      drive_req(1'b0);
      fence = 1'b1; enable = 1'b0;
      step(1);
      fence = 1'b0;
      drive_req(1'b1);
      step(1);
      chk("t3_fence_busy", fence_busy, 1'b1);
      chk("t3_outstanding", outstanding, 1);
      chk("t3_in_pkt_done", s_req_tready, 1'b0);
      drive_req(1'b1);
      step(3);
      chk("t3_new_head_blocked", nr_req_sent, 1);
      drive_rsp(1'b1);
      step(1);
      s_rsp_tvalid = 1'b0;
      chk("t3_outstanding_zero", outstanding, 0);
      chk("t3_busy_still", fence_busy, 1'b1);
      step(1);
      chk("t3_busy_fall", fence_busy, 1'b0);
      step(1);
      chk("t3_idle_blocks", nr_req_sent, 1);
      s_req_tvalid = 1'b0;

      // 4: unmatched response, then clear
      pulse_clear();
      drive_rsp(1'b1);
      step(1);
      s_rsp_tvalid = 1'b0;
      chk("t4_err_unmatched", err_unmatched, 1'b1);
      chk("t4_nr_rsp_recv", nr_rsp_recv, 1);
      chk("t4_lat_min", lat_min, 8'hff);
      chk("t4_lat_sum", lat_sum, 0);
      pulse_clear();
      chk("t4_clr_err", err_unmatched, 1'b0);
      chk("t4_clr_nr_rsp_recv", nr_rsp_recv, 0);
      chk("t4_clr_lat_min", lat_min, 8'hff);
      chk("t4_clr_lat_max", lat_max, 0);

      // 5: latency across timestamp wrap (head at 250, response at 4)
      enable = 1'b1;
      step(1);
      for (int g = 0; g < 300 && m_ts != 8'd250; g++) step(1);
      chk("t5_align_head", m_ts, 250);
      drive_req(1'b1);
      step(1);
      s_req_tvalid = 1'b0;
      for (int g = 0; g < 300 && m_ts != 8'd4; g++) step(1);
      chk("t5_align_rsp", m_ts, 4);
      drive_rsp(1'b1);
      step(1);
      s_rsp_tvalid = 1'b0;
      chk("t5_lat_min", lat_min, 10);
      chk("t5_lat_max", lat_max, 10);
      chk("t5_lat_sum", lat_sum, 10);

      // 6: asynchronous reset mid-packet with 3 outstanding
      drive_req(1'b1);
      step(1);
      drive_req(1'b1);
      step(1);
      drive_req(1'b0);
      step(1);
      drive_req(1'b0);
      chk("t6_outstanding_pre", outstanding, 3);
      #2;
      sys_rst = 1'b1;
      #1;
      chk("t6_rst_outstanding", outstanding, 0);
      chk("t6_rst_nr_req_sent", nr_req_sent, 0);
      chk("t6_rst_nr_rsp_recv", nr_rsp_recv, 0);
      chk("t6_rst_lat_min", lat_min, 8'hff);
      chk("t6_rst_lat_max", lat_max, 0);
      chk("t6_rst_lat_sum", lat_sum, 0);
      chk("t6_rst_s_req_tready", s_req_tready, 1'b0);
      chk("t6_rst_m_req_tvalid", m_req_tvalid, 1'b0);
      s_req_tvalid = 1'b0;
      step(2);
      sys_rst = 1'b0;
      step(1);
      drive_req(1'b1);
      step(1);
      s_req_tvalid = 1'b0;
      step(4);
      drive_rsp(1'b1);
      step(1);
      s_rsp_tvalid = 1'b0;
      chk("t6_post_nr_req_sent", nr_req_sent, 1);
      chk("t6_post_lat_min", lat_min, 5);
      chk("t6_post_lat_sum", lat_sum, 5);
      chk("t6_post_outstanding", outstanding, 0);
      chk("t6_post_err", err_unmatched, 1'b0);

      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
